inst_sequencer: RTL and testbench
=================================

INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The module SHALL take parameters, one per line, as name, default and meaning:
- INST_BITS, 140, instruction width: {opcode[139:136], addr[135:128], operand[127:0]}.
- OPCODE_BITS, 4, opcode field width; encodings are those defined in sa_share.v.
- DEPTH, 8, instruction FIFO entries; a power of two.
- MM_LATENCY, 31, cycles the systolic array needs to drain after a matmul issue (2N-1 for N=16).

REQ-002 The module SHALL have ports, one per line, as name, direction, width and meaning:
- clk, in, 1, the only clock, rising edge.
- reset_n, in, 1, reset.
- in_inst, in, INST_BITS, host instruction.
- in_valid, in, 1, in_inst is valid.
- in_ready, out, 1, the FIFO can accept an instruction.
- run, in, 1, level; 1 enables issue.
- flush, in, 1, synchronous FIFO discard.
- out_inst, out, INST_BITS, instruction to CONTROL_UNIT.instruction.
- out_valid, out, 1, out_inst carries a real (non-filler) instruction.
- fifo_count, out, $clog2(DEPTH)+1, current occupancy.
- busy, out, 1, work is pending.
- blocked, out, 1, the head instruction is held by a hazard.

REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 A push SHALL occur on a rising edge where in_valid && in_ready; in_ready SHALL be (fifo_count < DEPTH), with no full-bypass.
REQ-005 A simultaneous push and pop SHALL leave fifo_count unchanged; the FIFO pointers SHALL wrap modulo DEPTH.
REQ-006 Ordering SHALL be strictly FIFO; no instruction reordering.
REQ-007 Minimum latency: an instruction pushed at edge t into an empty FIFO, with run=1 and no hazard, SHALL appear on out_inst/out_valid after edge t+1.
REQ-008 At most one instruction SHALL issue per cycle; out_inst and out_valid SHALL be registered.
REQ-009 Any cycle with no issue SHALL drive out_inst = {IDLE_INST, zeros} with out_valid=0, so CONTROL_UNIT sees exactly one cycle per real instruction.
REQ-010 The internal drain counter drain_cnt SHALL behave as follows:
- Loaded with MM_LATENCY on issue of MAT_MUL_INST or MM_AND_LOAD_DATA_INST, including back-to-back reloads.
- Otherwise decremented while non-zero, saturating at 0.
REQ-011 Hazard: a head of LOAD_WEIGHT_INST or ACCUMULATION_INST SHALL NOT issue while drain_cnt != 0; all other opcodes, including unknown opcodes, SHALL issue without a hazard check.
REQ-012 Unknown opcodes SHALL pass through unchanged, with out_valid=1.
REQ-013 The FSM SHALL have states S_IDLE, S_ISSUE and S_WAIT:
- S_IDLE -> S_ISSUE: when run=1 and the FIFO is non-empty.
- S_ISSUE -> S_WAIT: when the head is hazard-blocked.
- S_ISSUE -> S_IDLE: when the FIFO is empty or run=0.
- S_WAIT -> S_ISSUE: in the cycle drain_cnt reaches 0; the blocked head issues on the next edge.
- S_WAIT -> S_IDLE: on run=0.
REQ-014 run=0 SHALL stop issue at the next edge; FIFO contents and drain_cnt SHALL be kept, and drain_cnt SHALL still count down.
REQ-015 flush=1 SHALL empty the FIFO, force the filler out_inst with out_valid=0, and return the FSM to S_IDLE at the next edge.
REQ-016 flush SHALL leave drain_cnt counting, because the array is still physically draining.
REQ-017 flush SHALL take priority over a same-cycle push, which is dropped, and over a same-cycle pop.
REQ-018 blocked SHALL be 1 when the FSM is in S_WAIT.
REQ-019 busy SHALL be (fifo_count != 0) || (drain_cnt != 0) || out_valid.
REQ-020 in_inst SHALL be stored unmodified, with no field decoding other than opcode inspection at the head.

Reset
REQ-021 reset_n=0 SHALL immediately clear the following, regardless of clk:
- FIFO pointers, with fifo_count=0.
- drain_cnt=0 and FSM=S_IDLE.
- out_inst = {IDLE_INST, zeros}, out_valid=0, blocked=0, busy=0.
REQ-022 in_ready SHALL be 0 while reset_n=0 and 1 from the first edge after release.
REQ-023 Reset asserted mid-drain or with a full FIFO SHALL discard all state; no instruction SHALL issue after release until it is newly pushed.

Verification
REQ-024 Basic issue: push WRITE_DATA(addr=0x05, operand=0xAA..) with run=1 -> exactly one cycle of out_valid=1 with identical bits after edge t+1, then filler.
REQ-025 Matmul hazard: push MAT_MUL then ACCUMULATION -> ACCUMULATION issues exactly MM_LATENCY+1 cycles after MAT_MUL, with blocked=1 during the gap.
REQ-026 No hazard on LOAD_DATA: push MAT_MUL then LOAD_DATA -> LOAD_DATA issues in the cycle after MAT_MUL.
REQ-027 Full FIFO: with run=0, push 8 instructions -> in_ready=0 and a 9th push is ignored; raise run -> 8 consecutive issues in order, fifo_count stepping 8..0.
REQ-028 Flush during hazard: MAT_MUL issued, LOAD_WEIGHT blocked, flush -> LOAD_WEIGHT never issues, FIFO empty, and busy stays 1 until drain_cnt=0.
REQ-029 Async reset at drain_cnt=10 with fifo_count=3 -> all outputs at reset values without a clock edge, and nothing issues after release.

Source files
------------

// File: rtl/inst_sequencer.sv
// inst_sequencer: instruction FIFO with run/flush control and a matmul drain hazard,
// issuing at most one registered instruction per cycle toward the control unit.
module inst_sequencer #(
  parameter int INST_BITS   = 140,
  parameter int OPCODE_BITS = 4,
  parameter int DEPTH       = 8,
  parameter int MM_LATENCY  = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [INST_BITS-1:0]     in_inst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     run,
  input  logic                     flush,
  output logic [INST_BITS-1:0]     out_inst,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     blocked
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(MM_LATENCY + 1);
  localparam logic [OPCODE_BITS-1:0] IDLE_INST             = 'd0;
  localparam logic [OPCODE_BITS-1:0] LOAD_WEIGHT_INST      = 'd2;
  localparam logic [OPCODE_BITS-1:0] MAT_MUL_INST          = 'd3;
  localparam logic [OPCODE_BITS-1:0] ACCUMULATION_INST     = 'd6;
  localparam logic [OPCODE_BITS-1:0] MM_AND_LOAD_DATA_INST = 'd7;
  localparam logic [INST_BITS-1:0]   FILL = {IDLE_INST, {(INST_BITS-OPCODE_BITS){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [INST_BITS-1:0]   mem [DEPTH];
  logic [AW-1:0]          wr_q, rd_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          drain_q, drain_d;
  state_t                 state_q, state_d;
  logic [INST_BITS-1:0]   out_inst_q;
  logic                   out_valid_q, rdy_q;
  logic [INST_BITS-1:0]   head;
  logic [OPCODE_BITS-1:0] op;
  logic                   empty, hazard, push, pop;

  assign head     = mem[rd_q];
  assign op       = head[INST_BITS-1 -: OPCODE_BITS];
  assign empty    = cnt_q == '0;
  assign hazard   = (op == LOAD_WEIGHT_INST || op == ACCUMULATION_INST) && drain_q != '0;
  // rdy_q keeps in_ready low through reset and until the first edge after release
  assign in_ready = rdy_q && (cnt_q < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = run && !empty && !hazard && !flush;
  assign drain_d  = pop && (op == MAT_MUL_INST || op == MM_AND_LOAD_DATA_INST) ? DW'(MM_LATENCY)
                                                                              : drain_q - DW'(drain_q != '0);

  assign out_inst   = out_inst_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = cnt_q;
  assign blocked    = state_q == S_WAIT;
  assign busy       = !empty || drain_q != '0 || out_valid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = run && !empty ? S_ISSUE : S_IDLE;
      S_ISSUE: state_d = empty || !run ? S_IDLE : hazard ? S_WAIT : S_ISSUE;
      S_WAIT:  state_d = !run ? S_IDLE : drain_q == '0 ? S_ISSUE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      state_q     <= S_IDLE;
      out_inst_q  <= FILL;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q       <= 1'b1;
      drain_q     <= drain_d;
      state_q     <= state_d;
      out_inst_q  <= pop ? head : FILL;
      out_valid_q <= pop;
      wr_q        <= flush ? '0 : wr_q + AW'(push);
      rd_q        <= flush ? '0 : rd_q + AW'(pop);
      cnt_q       <= flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= in_inst;
  end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: directed checks of issue latency, drain hazard, full FIFO,
// flush during a hazard and asynchronous reset.
module tb_inst_sequencer;
  localparam logic [3:0] LOAD_DATA_INST    = 4'd1;
  localparam logic [3:0] LOAD_WEIGHT_INST  = 4'd2;
  localparam logic [3:0] MAT_MUL_INST      = 4'd3;
  localparam logic [3:0] WRITE_DATA_INST   = 4'd4;
  localparam logic [3:0] ACCUMULATION_INST = 4'd6;
  localparam logic [139:0] FILL = '0;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic [139:0] in_inst = '0;
  logic         in_valid = 1'b0, run = 1'b0, flush = 1'b0;
  logic         in_ready, out_valid, busy, blocked;
  logic [139:0] out_inst;
  logic [3:0]   fifo_count;
  int           passed = 0, total = 0;

  inst_sequencer dut (
    .clk(clk), .reset_n(reset_n), .in_inst(in_inst), .in_valid(in_valid), .in_ready(in_ready),
    .run(run), .flush(flush), .out_inst(out_inst), .out_valid(out_valid),
    .fifo_count(fifo_count), .busy(busy), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [139:0] obs, input logic [139:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [139:0] mk(input logic [3:0] op, input logic [7:0] addr, input logic [127:0] v);
    return {op, addr, v};
  endfunction

  logic [139:0] w, items [8];
  int           n;
  bit           seen;

  initial begin
    #12;
    chk("rst_out_valid", 140'(out_valid), 140'(0));
    chk("rst_out_inst", out_inst, FILL);
    chk("rst_count", 140'(fifo_count), 140'(0));
    chk("rst_busy", 140'(busy), 140'(0));
    chk("rst_blocked", 140'(blocked), 140'(0));
    chk("rst_in_ready", 140'(in_ready), 140'(0));
    reset_n = 1'b1;
    tick();
    chk("ready_after_release", 140'(in_ready), 140'(1));

    // basic issue with minimum latency
    run = 1'b1;
    w = mk(WRITE_DATA_INST, 8'h05, {16{8'hAA}});
    in_inst = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("basic_count1", 140'(fifo_count), 140'(1));
    chk("basic_not_yet", 140'(out_valid), 140'(0));
    tick();
    chk("basic_valid", 140'(out_valid), 140'(1));
    chk("basic_bits", out_inst, w);
    chk("basic_busy", 140'(busy), 140'(1));
    tick();
    chk("basic_filler_valid", 140'(out_valid), 140'(0));
    chk("basic_filler_inst", out_inst, FILL);
    chk("basic_idle_busy", 140'(busy), 140'(0));

    // matmul then accumulation: blocked for MM_LATENCY cycles
    in_inst = mk(MAT_MUL_INST, 8'h01, 128'h11); in_valid = 1'b1;
    tick();
    in_inst = mk(ACCUMULATION_INST, 8'h02, 128'h22);
    tick();
    in_valid = 1'b0;
    chk("mm_issue", out_inst, mk(MAT_MUL_INST, 8'h01, 128'h11));
    chk("mm_pushpop_count", 140'(fifo_count), 140'(1));
    n = 0;
    do begin
      tick();
      n++;
      if (n == 16) begin
        chk("acc_blocked", 140'(blocked), 140'(1));
        chk("acc_busy", 140'(busy), 140'(1));
      end
    end while (!out_valid && n < 40);
    chk("acc_gap", 140'(n), 140'(32));
    chk("acc_bits", out_inst, mk(ACCUMULATION_INST, 8'h02, 128'h22));
    chk("acc_count", 140'(fifo_count), 140'(0));

    // matmul then load_data: no hazard
    in_inst = mk(MAT_MUL_INST, 8'h03, 128'h33); in_valid = 1'b1;
    tick();
    in_inst = mk(LOAD_DATA_INST, 8'h04, 128'h44);
    tick();
    in_valid = 1'b0;
    chk("mm2_issue", out_inst, mk(MAT_MUL_INST, 8'h03, 128'h33));
    tick();
    chk("ld_valid", 140'(out_valid), 140'(1));
    chk("ld_bits", out_inst, mk(LOAD_DATA_INST, 8'h04, 128'h44));
    repeat (35) tick();
    chk("drain_done_busy", 140'(busy), 140'(0));

    // full FIFO with run low, then in-order drain
    run = 1'b0;
    for (int i = 0; i < 8; i++) begin
      items[i] = mk(i == 0 ? WRITE_DATA_INST : 4'(8 + i), 8'(i), {4{32'hA5A50000 + i}});
      in_inst = items[i]; in_valid = 1'b1;
      tick();
    end
    chk("full_count", 140'(fifo_count), 140'(8));
    chk("full_ready", 140'(in_ready), 140'(0));
    in_inst = mk(WRITE_DATA_INST, 8'hFF, '1);
    tick();
    in_valid = 1'b0;
    chk("ninth_dropped", 140'(fifo_count), 140'(8));
    chk("run0_no_issue", 140'(out_valid), 140'(0));
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("order_bits%0d", i), out_inst, items[i]);
      chk($sformatf("order_valid%0d", i), 140'(out_valid), 140'(1));
      chk($sformatf("order_count%0d", i), 140'(fifo_count), 140'(7 - i));
    end
    tick();
    chk("order_end", 140'(out_valid), 140'(0));

    // flush while load_weight is held behind a matmul
    in_inst = mk(MAT_MUL_INST, 8'h05, 128'h55); in_valid = 1'b1;
    tick();
    in_inst = mk(LOAD_WEIGHT_INST, 8'h06, 128'h66);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("lw_blocked", 140'(blocked), 140'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 140'(fifo_count), 140'(0));
    chk("flush_valid", 140'(out_valid), 140'(0));
    chk("flush_blocked", 140'(blocked), 140'(0));
    chk("flush_busy", 140'(busy), 140'(1));
    n = 0;
    seen = 1'b0;
    while (busy && n < 40) begin
      tick();
      n++;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_drain_cycles", 140'(n), 140'(28));
    chk("flush_lw_never", 140'(seen), 140'(0));

    // asynchronous reset mid-drain with three queued
    in_inst = mk(MAT_MUL_INST, 8'h07, 128'h77); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_mm_issue", 140'(out_valid), 140'(1));
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_inst = mk(WRITE_DATA_INST, 8'(16 + i), 128'(i)); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (18) tick();
    chk("pre_rst_count", 140'(fifo_count), 140'(3));
    chk("pre_rst_busy", 140'(busy), 140'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_count", 140'(fifo_count), 140'(0));
    chk("async_busy", 140'(busy), 140'(0));
    chk("async_valid", 140'(out_valid), 140'(0));
    chk("async_inst", out_inst, FILL);
    chk("async_ready", 140'(in_ready), 140'(0));
    chk("async_blocked", 140'(blocked), 140'(0));
    reset_n = 1'b1;
    run = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_no_issue", 140'(seen), 140'(0));
    chk("post_rst_count", 140'(fifo_count), 140'(0));
    chk("post_rst_ready", 140'(in_ready), 140'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
